barrel_sched: RTL

- Two-requester scheduler and sequencer for the shared registered barrel rotator.
- Arbitrates between requesters round-robin and latches the winning operand and rotate amount.
- Drives the rotator's load/select over as many passes as the amount needs (each pass at most DATA_SIZE-1 positions).
- Returns the rotated word with the winner's ID over a valid/ready response channel.
- Sits between the client blocks and the single rotator instance.

---
 rtl/barrel_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/barrel_sched.sv
// ---------------------------------------------------------------------------
// barrel_sched
//   Two-requester round-robin scheduler and pass sequencer for a shared,
//   registered barrel rotator. The winning operand and rotate amount are
//   latched, then the rotator is driven for as many passes as the amount
//   needs (each pass rotates by at most DATA_SIZE-1). The result is returned
//   with the winner's ID on a valid/ready response channel.
//
// Ports
//   clk, reset                  clock (rising edge), async active-high reset
//   req{0,1}_valid/ready        request handshake per requester
//   req{0,1}_data/amt           operand and right-rotate amount
//   brl_load/sel/data_in        rotator controls (load: 1 = take data_in)
//   brl_data_out                rotator registered output
//   rsp_valid/ready/data/id     response handshake, result and owner ID
//   busy                        high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module barrel_sched #(
  parameter int DATA_SIZE = 8,
  parameter int SEL_W     = 3,
  parameter int AMT_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DATA_SIZE-1:0] req0_data,
  input  logic [AMT_W-1:0]     req0_amt,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [DATA_SIZE-1:0] req1_data,
  input  logic [AMT_W-1:0]     req1_amt,
  output logic                 brl_load,
  output logic [SEL_W-1:0]     brl_sel,
  output logic [DATA_SIZE-1:0] brl_data_in,
  input  logic [DATA_SIZE-1:0] brl_data_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_SIZE-1:0] rsp_data,
  output logic                 rsp_id,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Largest rotate the rotator can perform in a single pass.
  localparam logic [AMT_W-1:0] MAX_CHUNK = AMT_W'(DATA_SIZE - 1);

  logic [1:0]           state_q, state_d;
  logic                 rr_last_q, rr_last_d;
  logic [AMT_W-1:0]     rem_q, rem_d;
  logic                 first_q, first_d;
  logic                 id_q, id_d;
  logic [DATA_SIZE-1:0] data_in_q, data_in_d;

  logic                 grant0, grant1;
  logic                 idle, in_pass, in_done, accept;
  logic [AMT_W-1:0]     chunk, rem_next;

  // Round-robin grant: on contention, the requester that did not win last.
  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      grant0 = rr_last_q;
      grant1 = !rr_last_q;
    end
  end

  assign idle    = (state_q == ST_IDLE);
  assign in_pass = (state_q == ST_PASS);
  assign in_done = (state_q == ST_DONE);

  // Ready is suppressed while reset is held so nothing is offered then.
  assign req0_ready = idle && grant0 && !reset;
  assign req1_ready = idle && grant1 && !reset;
  assign accept     = req0_ready || req1_ready;

  assign chunk    = (rem_q > MAX_CHUNK) ? MAX_CHUNK : rem_q;
  assign rem_next = rem_q - chunk;

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    rem_d     = rem_q;
    first_d   = first_q;
    id_d      = id_q;
    data_in_d = data_in_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_in_d = req1_ready ? req1_data : req0_data;
          rem_d     = req1_ready ? req1_amt  : req0_amt;
          id_d      = req1_ready;
          rr_last_d = req1_ready;
          first_d   = 1'b1;
          state_d   = ST_PASS;
        end
      end
      ST_PASS: begin
        // An amount of 0 still runs one pass so the operand gets loaded.
        rem_d   = rem_next;
        first_d = 1'b0;
        if (rem_next == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      rem_q     <= '0;
      first_q   <= 1'b0;
      id_q      <= 1'b0;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      id_q      <= id_d;
      data_in_q <= data_in_d;
    end
  end

  // Outside PASS the rotator recirculates its own output with a 0 rotate,
  // which keeps the result stable while the response waits for ready.
  assign brl_load    = in_pass && first_q;
  assign brl_sel     = in_pass ? SEL_W'(chunk) : '0;
  assign brl_data_in = data_in_q;

  assign rsp_valid = in_done;
  assign rsp_data  = in_done ? brl_data_out : '0;
  assign rsp_id    = in_done && id_q;
  assign busy      = !idle;

endmodule
